// File: rtl/decode_ibuf.sv
// Instruction buffer between fetch and decode: a DEPTH-entry FIFO of {pc, inst, bd, exc}
// with push-time predecode, full flush and branch-shadow flush.
module decode_ibuf #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             fe_valid,
   output logic             fe_ready,
   input  logic [PC_W-1:0]  fe_pc,
   input  logic [31:0]      fe_inst,
   output logic             de_valid,
   input  logic             de_ready,
   output logic [PC_W-1:0]  de_pc,
   output logic [31:0]      de_inst,
   output logic             de_bd,
   output logic [2:0]       de_exc,
   input  logic             flush,
   input  logic             br_flush,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [PC_W-1:0]  pc_mem   [DEPTH];
   logic [31:0]      inst_mem [DEPTH];
   logic             bd_mem   [DEPTH];
   logic [2:0]       exc_mem  [DEPTH];

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             prev_cti;
   logic             keep_next;

   logic [5:0]       op;
   logic [5:0]       funct;
   logic [4:0]       rt;
   logic             is_cti;
   logic             cti_eff;
   logic [2:0]       exc_in;
   logic [31:0]      inst_in;

   logic             push;
   logic             pop;
   logic             has_slot;
   logic             shadow_cut;
   logic             wr_en;

   assign op    = fe_inst[31:26];
   assign rt    = fe_inst[20:16];
   assign funct = fe_inst[5:0];

   always_comb begin
      is_cti = 1'b0;
      case (op)
         6'b000010, 6'b000011, 6'b000100,
         6'b000101, 6'b000110, 6'b000111: is_cti = 1'b1;
         6'b000001: is_cti = (rt == 5'b00000) || (rt == 5'b00001) ||
                             (rt == 5'b10000) || (rt == 5'b10001);
         6'b000000: is_cti = (funct == 6'b001000) || (funct == 6'b001001);
         default:   is_cti = 1'b0;
      endcase
   end

   // Fetch address error wins over every instruction-derived exception.
   always_comb begin
      exc_in = 3'd0;
      if (fe_pc[1:0] != 2'b00)                      exc_in = 3'd1;
      else if (op == 6'd0 && funct == 6'b001100)    exc_in = 3'd2;
      else if (op == 6'd0 && funct == 6'b001101)    exc_in = 3'd3;
      else if (fe_inst == 32'h4200_0018)            exc_in = 3'd4;
   end

   assign inst_in = (exc_in == 3'd1) ? 32'd0 : fe_inst;
   assign cti_eff = is_cti && (exc_in != 3'd1);

   assign full     = (cnt == CNT_W'(DEPTH));
   assign empty    = (cnt == '0);
   assign fe_ready = ~full;
   assign de_valid = ~empty;
   assign count    = cnt;

   assign push       = fe_valid & fe_ready;
   assign pop        = de_valid & de_ready;
   assign has_slot   = (cnt >= CNT_W'(2));
   // Taken branch at head with its delay slot already queued: keep only the slot.
   assign shadow_cut = pop & br_flush & has_slot;
   assign wr_en      = push & ~flush & ~shadow_cut;

   assign de_pc   = pc_mem[rd_ptr];
   assign de_inst = inst_mem[rd_ptr];
   assign de_bd   = bd_mem[rd_ptr];
   assign de_exc  = exc_mem[rd_ptr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
            bd_mem[i]   <= 1'b0;
            exc_mem[i]  <= 3'd0;
         end
      end else if (wr_en) begin
         pc_mem[wr_ptr]   <= fe_pc;
         inst_mem[wr_ptr] <= inst_in;
         bd_mem[wr_ptr]   <= prev_cti;
         exc_mem[wr_ptr]  <= exc_in;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         prev_cti  <= 1'b0;
         keep_next <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         prev_cti  <= 1'b0;
         keep_next <= 1'b0;
      end else if (shadow_cut) begin
         // The retained slot is never a CTI on a correct path, so the next push is not in a slot.
         rd_ptr    <= rd_ptr + AW'(1);
         wr_ptr    <= rd_ptr + AW'(2);
         cnt       <= CNT_W'(1);
         prev_cti  <= 1'b0;
         keep_next <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + AW'(1);
            prev_cti <= cti_eff;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
         if (pop && br_flush && !push) begin
            keep_next <= 1'b1;
         end else if (push) begin
            keep_next <= 1'b0;
         end
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (resetn) begin
         assert (cnt <= CNT_W'(DEPTH)) else $error("decode_ibuf: occupancy above DEPTH");
         assert (!(pop && cnt == '0)) else $error("decode_ibuf: pop from empty buffer");
      end
   end
`endif

endmodule

// File: tb/tb_decode_ibuf.sv
// Bench for decode_ibuf: directed scenarios plus random traffic, scored against a
// queue-based model of the buffer contents.
module tb_decode_ibuf;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int EW    = PC_W + 32 + 1 + 3;

   logic             clk;
   logic             resetn;
   logic             fe_valid;
   logic             fe_ready;
   logic [PC_W-1:0]  fe_pc;
   logic [31:0]      fe_inst;
   logic             de_valid;
   logic             de_ready;
   logic [PC_W-1:0]  de_pc;
   logic [31:0]      de_inst;
   logic             de_bd;
   logic [2:0]       de_exc;
   logic             flush;
   logic             br_flush;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;

   logic [EW-1:0] exp_q[$];
   logic          m_prev_cti;
   int            checks;
   int            failures;

   decode_ibuf #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn),
      .fe_valid(fe_valid), .fe_ready(fe_ready), .fe_pc(fe_pc), .fe_inst(fe_inst),
      .de_valid(de_valid), .de_ready(de_ready), .de_pc(de_pc), .de_inst(de_inst),
      .de_bd(de_bd), .de_exc(de_exc),
      .flush(flush), .br_flush(br_flush),
      .count(count), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] exc_of(input logic [31:0] pc, input logic [31:0] inst);
      if (pc[1:0] != 2'b00) return 3'd1;
      if (inst[31:26] == 6'd0 && inst[5:0] == 6'd12) return 3'd2;
      if (inst[31:26] == 6'd0 && inst[5:0] == 6'd13) return 3'd3;
      if (inst == 32'h4200_0018) return 3'd4;
      return 3'd0;
   endfunction

   function automatic logic cti_of(input logic [31:0] pc, input logic [31:0] inst);
      int op, rt, fn;
      op = int'(inst[31:26]);
      rt = int'(inst[20:16]);
      fn = int'(inst[5:0]);
      if (exc_of(pc, inst) == 3'd1) return 1'b0;
      if (op inside {2, 3, 4, 5, 6, 7}) return 1'b1;
      if (op == 1 && (rt inside {0, 1, 16, 17})) return 1'b1;
      if (op == 0 && (fn inside {8, 9})) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [EW-1:0] mk_entry(input logic [31:0] pc, input logic [31:0] inst,
                                              input logic bd);
      logic [2:0] e;
      e = exc_of(pc, inst);
      return {pc, (e == 3'd1) ? 32'd0 : inst, bd, e};
   endfunction

   // One clock of stimulus; the model update lands on the edge that commits it.
   task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl, input logic bf);
      int n;
      logic acc, popm;
      logic [EW-1:0] e;
      fe_valid = v; fe_pc = pc; fe_inst = inst; de_ready = rdy; flush = fl; br_flush = bf;
      n    = exp_q.size();
      acc  = v && (n < DEPTH);
      popm = rdy && (n > 0);
      e    = mk_entry(pc, inst, m_prev_cti);
      @(posedge clk);
      if (fl) begin
         exp_q.delete();
         m_prev_cti = 1'b0;
      end else if (bf && popm && n >= 2) begin
         while (exp_q.size() > 1) void'(exp_q.pop_back());
         m_prev_cti = 1'b0;
      end else if (acc) begin
         exp_q.push_back(e);
         m_prev_cti = cti_of(pc, inst);
      end
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("drain_empty", 128'(empty), 128'(1));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_count"}, 128'(count), 128'(0));
      chk({tag, "_empty"}, 128'(empty), 128'(1));
      chk({tag, "_full"}, 128'(full), 128'(0));
      chk({tag, "_de_valid"}, 128'(de_valid), 128'(0));
      chk({tag, "_fe_ready"}, 128'(fe_ready), 128'(1));
      chk({tag, "_de_fields"}, 128'({de_pc, de_inst, de_bd, de_exc}), 128'(0));
   endtask

   always @(negedge clk) begin : monitor
      int n;
      logic [EW-1:0] e;
      if (resetn) begin
         n = exp_q.size();
         chk("count", 128'(count), 128'(n));
         chk("de_valid", 128'(de_valid), 128'(n != 0));
         chk("fe_ready", 128'(fe_ready), 128'(n < DEPTH));
         chk("full", 128'(full), 128'(n == DEPTH));
         chk("empty", 128'(empty), 128'(n == 0));
         if (de_valid && de_ready && !flush) begin
            if (n == 0) begin
               checks++;
               failures++;
               $display("FAIL pop_unexpected got=pop exp=no_entry at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("head_entry", 128'({de_pc, de_inst, de_bd, de_exc}), 128'(e));
            end
         end
      end
   end

   logic [31:0] inst_tab [12];

   initial begin
      logic [31:0] rpc, rinst;
      inst_tab[0] = 32'h1000_0003; inst_tab[1] = 32'h0800_0010; inst_tab[2] = 32'h0c00_0010;
      inst_tab[3] = 32'h0400_0004; inst_tab[4] = 32'h0411_0004; inst_tab[5] = 32'h0402_0004;
      inst_tab[6] = 32'h03e0_0008; inst_tab[7] = 32'h0040_f809; inst_tab[8] = 32'h0000_000c;
      inst_tab[9] = 32'h0000_000d; inst_tab[10] = 32'h4200_0018; inst_tab[11] = 32'h0085_1021;
      checks = 0; failures = 0; m_prev_cti = 1'b0;
      resetn = 1'b0; fe_valid = 0; fe_pc = 0; fe_inst = 0; de_ready = 0; flush = 0; br_flush = 0;
      #12;
      chk_reset_vals("reset");
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;

      // Fill to full, then one pop.
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'hbfc0_0000 + 32'(4 * i), 32'h0085_1021, 1'b0, 1'b0, 1'b0);
      chk("fill_count", 128'(count), 128'(4));
      chk("fill_full", 128'(full), 128'(1));
      chk("fill_fe_ready", 128'(fe_ready), 128'(0));
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("pop_fe_ready", 128'(fe_ready), 128'(1));
      chk("pop_head_pc", 128'(de_pc), 128'(32'hbfc0_0004));
      drain();

      // Delay slot tagging: beq, addu, or.
      cycle(1'b1, 32'h100, 32'h1000_0003, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h104, 32'h0085_1021, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h108, 32'h0085_1025, 1'b0, 1'b0, 1'b0);
      chk("bd_head0", 128'(de_bd), 128'(0));
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("bd_head1", 128'(de_bd), 128'(1));
      drain();

      // Branch-shadow flush with slot queued, then with slot arriving on the same cycle.
      cycle(1'b1, 32'h200, 32'h1000_0003, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h204, 32'h0085_1021, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h208, 32'h0085_1025, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h20c, 32'h0085_1025, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h210, 32'h0085_1025, 1'b1, 1'b0, 1'b1);
      chk("brf_count", 128'(count), 128'(1));
      chk("brf_head_pc", 128'(de_pc), 128'(32'h204));
      drain();
      cycle(1'b1, 32'h300, 32'h1000_0003, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h304, 32'h0085_1021, 1'b1, 1'b0, 1'b1);
      chk("brf_slot_pc", 128'(de_pc), 128'(32'h304));
      chk("brf_slot_bd", 128'(de_bd), 128'(1));
      drain();

      // Early exceptions.
      cycle(1'b1, 32'h102, 32'h0085_1021, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h104, 32'h0000_000c, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h108, 32'h0000_000d, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h10c, 32'h4200_0018, 1'b0, 1'b0, 1'b0);
      chk("exc1_code", 128'(de_exc), 128'(1));
      chk("exc1_inst", 128'(de_inst), 128'(0));
      drain();
      cycle(1'b1, 32'h10a, 32'h0000_000c, 1'b0, 1'b0, 1'b0);
      chk("exc_prio", 128'(de_exc), 128'(1));
      drain();

      // Full flush with push and pop pending, last entry a jr.
      cycle(1'b1, 32'h400, 32'h0085_1021, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h404, 32'h0085_1021, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h408, 32'h03e0_0008, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h40c, 32'h0085_1021, 1'b1, 1'b1, 1'b0);
      chk("flush_count", 128'(count), 128'(0));
      chk("flush_de_valid", 128'(de_valid), 128'(0));
      cycle(1'b1, 32'h500, 32'h0085_1021, 1'b0, 1'b0, 1'b0);
      chk("flush_bd", 128'(de_bd), 128'(0));
      drain();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         rpc = $urandom() & 32'hffff_fffc;
         if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
         rinst = ($urandom_range(0, 3) == 0) ? $urandom() : inst_tab[$urandom_range(0, 11)];
         cycle(1'($urandom_range(0, 1)), rpc, rinst, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0));
      end
      drain();

      // Asynchronous reset between clock edges.
      cycle(1'b1, 32'h600, 32'h0085_1021, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h604, 32'h1000_0003, 1'b0, 1'b0, 1'b0);
      fe_valid = 1'b0;
      chk("pre_areset_count", 128'(count), 128'(2));
      #2 resetn = 1'b0;
      #1;
      chk_reset_vals("areset");
      exp_q.delete();
      m_prev_cti = 1'b0;
      #3 resetn = 1'b1;
      @(posedge clk); #1;
      cycle(1'b1, 32'h700, 32'h0085_1021, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h704, 32'h0085_1025, 1'b0, 1'b0, 1'b0);
      chk("post_reset_bd", 128'(de_bd), 128'(0));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
